dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised big-endian byte-addressed data memory for the RISC-V core's load/store unit.
- Adds a valid/ready request port, a registered 1-cycle response and a sequential post-reset clear engine.
- Misaligned accesses are handled in two beats, or flagged as errors when the optional feature is compiled out.
- Sits between the LSU and the word-organised on-chip RAM.

Parameters:
- ADDR_WIDTH, 10, byte-address width; storage = 2**(ADDR_WIDTH-2) words of 32 bits (ADDR_WIDTH >= 3).
- CLEAR_ON_RESET, 1, 1 = walk all words writing 0 after reset; 0 = skip INIT, contents undefined.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready
- req_we  input  1  1 = store, 0 = load
- req_mode  input  3  000 word, 001 unsigned half, 010 signed half, 011 unsigned byte, 100 signed byte, 101-111 = word
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  32  store data; half uses [15:0], byte uses [7:0]
- rsp_valid  output  1  one-cycle response pulse, no backpressure
- rsp_rdata  output  32  load data, sign/zero extended; 0 for stores and errors
- rsp_err  output  1  misaligned access rejected (feature off only)
- init_done  output  1  high once the clear sequence has finished

Behaviour:
- Byte order:
  - word index w = addr[ADDR_WIDTH-1:2], lane k = addr[1:0].
  - Lane 0 = bits 31:24 (byte at the lowest address is most significant).
  - Half at a = {byte a, byte a+1}.
- Reset (reset low, asynchronous):
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
  - Clear pointer=0.
  - State goes to INIT if CLEAR_ON_RESET, else IDLE with init_done=1.
- Reset mid-operation aborts any beat or clear and restarts from INIT; a dropped request gets no response.
- INIT:
  - Writes 0 to word[ptr] each cycle, ptr++.
  - After the last word: init_done=1 and go to IDLE. Duration is exactly 2**(ADDR_WIDTH-2) cycles.
  - req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - On handshake, an aligned access completes in that cycle's RAM operation.
  - rsp_valid=1 the next cycle, so back-to-back requests are accepted every cycle.
- Misalignment:
  - Word with k!=0, or half with k==3.
  - Byte accesses are never misaligned.
- SPLIT:
  - Entered on a misaligned handshake when the feature is on.
  - Beat 1 (accept cycle) covers word w, lanes k..3. Beat 2 (next cycle, in SPLIT, req_ready=0) covers word w+1, remaining lanes.
  - w+1 wraps to 0 from the last word.
  - rsp_valid asserts the cycle after beat 2, giving 2-cycle latency; the state returns to IDLE on beat 2.
- Stores:
  - Byte-lane masked write; only addressed bytes change.
  - The response carries rsp_rdata=0.
- Loads: assemble bytes, then zero-extend (001/011) or sign-extend from the top assembled byte (010/100).
- A load issued the cycle after a store to the same address returns the new data, because the write completes in the accept cycle.
- rsp_valid is a single-cycle pulse; rsp_rdata holds its value until the next response.

Optional Feature:
- Macro: DMEM_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are split as in SPLIT; rsp_err is tied to 0.
- Undefined:
  - A misaligned request is accepted with no memory change.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - The SPLIT state is not built.

Test Plan:
- Reset low 3 cycles then high, ADDR_WIDTH=10 -> req_ready=0 for exactly 256 cycles, then init_done=1; a word load at 0x3FC returns 0x00000000.
- Store word 0x80F1_2345 at 0x10, then signed-half load at 0x10 -> 0xFFFF80F1; unsigned-byte load at 0x13 -> 0x00000045; signed-byte load at 0x11 -> 0xFFFFFFF1.
- Store byte 0xAA at 0x22 over word 0x11223344 at 0x20 -> word load at 0x20 returns 0x1122AA44.
- Back-to-back requests: store then load at the same address in consecutive cycles -> two consecutive rsp_valid pulses; the load returns the stored data.
- Misaligned word load at 0x3FE, with words 0x3FC=0x0000_A1B2 and 0x000=0xC3D4_0000:
  - Feature on -> 0xA1B2C3D4 after 2 cycles.
  - Feature off -> rsp_err=1, rdata 0.
- Reset asserted during SPLIT beat 2 -> no rsp_valid, INIT restarts, memory reads 0 afterwards.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: big-endian, byte-addressed data memory for the LSU.
//   - valid/ready request port, registered one-cycle response pulse
//   - sequential zero-fill of every word after reset (CLEAR_ON_RESET)
//   - optional two-beat handling of misaligned accesses, enabled by
//     defining DMEM_MISALIGN_SPLIT_EN; without it a misaligned request is
//     accepted, leaves memory untouched and is answered with rsp_err=1.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; while req_valid is high and req_ready low the
// requester holds req_* stable. rsp_valid is a single-cycle pulse with no
// backpressure; rsp_rdata and rsp_err hold until the next response.
// dbg_state exposes the controller state (0 INIT, 1 IDLE, 2 SPLIT).
module dmem_ctrl #(
  parameter int ADDR_WIDTH     = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done,
  output logic [1:0]            dbg_state
);

  localparam int WW     = ADDR_WIDTH - 2;
  localparam int NWORDS = 1 << WW;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_SPLIT = 2'd2
  } state_t;

  // Access size in bytes for a mode code (101-111 behave as word).
  function automatic logic [2:0] mode_size(input logic [2:0] m);
    case (m)
      3'b001, 3'b010: return 3'd2;
      3'b011, 3'b100: return 3'd1;
      default:        return 3'd4;
    endcase
  endfunction

  // Store data left-justified so that byte i of the access sits at [31-8i -: 8].
  function automatic logic [31:0] mode_stream(input logic [2:0] m, input logic [31:0] d);
    case (m)
      3'b001, 3'b010: return {d[15:0], 16'h0000};
      3'b011, 3'b100: return {d[7:0], 24'h000000};
      default:        return d;
    endcase
  endfunction

  // Right-align the assembled (left-justified) load bytes and extend them.
  function automatic logic [31:0] mode_extend(input logic [2:0] m, input logic [31:0] s);
    case (m)
      3'b001:  return {16'h0000, s[31:16]};
      3'b010:  return {{16{s[31]}}, s[31:16]};
      3'b011:  return {24'h000000, s[31:24]};
      3'b100:  return {{24{s[31]}}, s[31:24]};
      default: return s;
    endcase
  endfunction

  state_t          state;
  logic [WW-1:0]   init_ptr;
  logic [31:0]     mem [0:NWORDS-1];

`ifdef DMEM_MISALIGN_SPLIT_EN
  // Request captured on the first beat of a split access.
  logic [ADDR_WIDTH-1:0] sp_addr;
  logic [2:0]            sp_mode;
  logic                  sp_we;
  logic [31:0]           sp_wdata;
  logic [31:0]           sp_part;
`endif

  logic                  hs;
  logic                  req_misal;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [2:0]            cur_mode;
  logic                  cur_we;
  logic [31:0]           cur_wdata;
  logic                  beat2;
  logic [31:0]           base;
  logic [2:0]            cur_size;
  logic [1:0]            cur_k;
  logic [31:0]           cur_stream;
  logic [WW-1:0]         cur_word;
  logic [31:0]           rd_word;
  logic [31:0]           lane_mask;
  logic [31:0]           wr_word;
  logic [31:0]           asm_data;
  logic                  op_go;
  logic                  err_now;

  assign dbg_state = state;
  assign hs        = (state == S_IDLE) && req_valid && req_ready;
  assign req_misal = ((mode_size(req_mode) == 3'd4) && (req_addr[1:0] != 2'd0)) ||
                     ((mode_size(req_mode) == 3'd2) && (req_addr[1:0] == 2'd3));

  // Select which request drives this cycle's RAM beat: the live request, or the saved one for beat 2.
  always_comb begin
    cur_addr  = req_addr;
    cur_mode  = req_mode;
    cur_we    = req_we;
    cur_wdata = req_wdata;
    beat2     = 1'b0;
    base      = 32'h0;
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (state == S_SPLIT) begin
      cur_addr  = sp_addr;
      cur_mode  = sp_mode;
      cur_we    = sp_we;
      cur_wdata = sp_wdata;
      beat2     = 1'b1;
      base      = sp_part;
    end
`endif
  end

  assign cur_size   = mode_size(cur_mode);
  assign cur_k      = cur_addr[1:0];
  assign cur_stream = mode_stream(cur_mode, cur_wdata);
  // Beat 2 targets the following word; the addition wraps from the last word to 0.
  assign cur_word   = cur_addr[ADDR_WIDTH-1:2] + WW'(beat2);
  assign rd_word    = mem[cur_word];

`ifdef DMEM_MISALIGN_SPLIT_EN
  assign op_go   = hs || (state == S_SPLIT);
  assign err_now = 1'b0;
`else
  assign op_go   = hs && !req_misal;
  assign err_now = hs && req_misal;
`endif

  // Map access bytes onto RAM lanes: lane j holds access byte j-k (beat 1) or j+4-k (beat 2).
  always_comb begin
    int bi;
    bi        = 0;
    lane_mask = 32'h0;
    wr_word   = 32'h0;
    asm_data  = base;
    for (int j = 0; j < 4; j++) begin
      bi = beat2 ? (j + 4 - int'(cur_k)) : (j - int'(cur_k));
      if (bi >= 0 && bi < int'(cur_size)) begin
        lane_mask[31-8*j -: 8] = 8'hFF;
        wr_word[31-8*j -: 8]   = cur_stream[31-8*bi -: 8];
        asm_data[31-8*bi -: 8] = rd_word[31-8*j -: 8];
      end
    end
  end

  // RAM write port: zero-fill during INIT, otherwise a lane-masked store beat.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[init_ptr] <= 32'h0;
    end else if (op_go && cur_we) begin
      mem[cur_word] <= (rd_word & ~lane_mask) | wr_word;
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CLEAR_ON_RESET ? S_INIT : S_IDLE;
      init_ptr  <= '0;
      req_ready <= ~CLEAR_ON_RESET;
      init_done <= ~CLEAR_ON_RESET;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
      sp_addr   <= '0;
      sp_mode   <= 3'b000;
      sp_we     <= 1'b0;
      sp_wdata  <= 32'h0;
      sp_part   <= 32'h0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (&init_ptr) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (hs) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
            if (req_misal) begin
              state     <= S_SPLIT;
              req_ready <= 1'b0;
              sp_addr   <= req_addr;
              sp_mode   <= req_mode;
              sp_we     <= req_we;
              sp_wdata  <= req_wdata;
              sp_part   <= asm_data;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= req_we ? 32'h0 : mode_extend(req_mode, asm_data);
            end
`else
            rsp_valid <= 1'b1;
            rsp_err   <= err_now;
            rsp_rdata <= (req_we || err_now) ? 32'h0 : mode_extend(req_mode, asm_data);
`endif
          end
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        S_SPLIT: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= sp_we ? 32'h0 : mode_extend(sp_mode, asm_data);
        end
`endif
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (ADDR_WIDTH=10, CLEAR_ON_RESET=1).
// Expected values are hand-computed big-endian results; misaligned cases
// select their expectation by whether DMEM_MISALIGN_SPLIT_EN is defined.
module tb_dmem_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_mode = 3'b000;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          init_done;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  dmem_ctrl #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_mode  (req_mode),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Release reset at a falling edge and count cycles until req_ready rises (bounded).
  task automatic release_and_count(output int cnt);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    while (req_ready !== 1'b1 && cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  // ---------------- driver ----------------
  // One request; returns the response and cycles from accept edge to rsp_valid, capped at 5 when no response arrives.
  task automatic do_access(input logic we, input logic [2:0] mode, input logic [AW-1:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 5) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int cnt;
    logic [31:0] rd;
    logic er;
    int lat;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 00000000", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", rsp_err); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    release_and_count(cnt);
    checks++; if (cnt != 256) begin failures++; $display("FAIL init_cycles: got %0d expected 256", cnt); end
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_done: got %b expected 1", init_done); end
    do_access(1'b0, 3'b000, 10'h3FC, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL load_3fc_after_init: got %h expected 00000000", rd); end
    checks++; if (lat != 1) begin failures++; $display("FAIL aligned_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_store_load;
    logic [31:0] rd;
    logic er;
    int lat;
    do_access(1'b1, 3'b000, 10'h010, 32'h80F1_2345, rd, er, lat);
    checks++; if (rd !== 32'h0 || lat != 1) begin failures++; $display("FAIL store_rsp: got %h lat %0d expected 00000000 lat 1", rd, lat); end
    do_access(1'b0, 3'b010, 10'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_80F1) begin failures++; $display("FAIL shalf_0x10: got %h expected ffff80f1", rd); end
    do_access(1'b0, 3'b011, 10'h013, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_0045) begin failures++; $display("FAIL ubyte_0x13: got %h expected 00000045", rd); end
    do_access(1'b0, 3'b100, 10'h011, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_FFF1) begin failures++; $display("FAIL sbyte_0x11: got %h expected fffffff1", rd); end
    do_access(1'b0, 3'b001, 10'h012, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_2345) begin failures++; $display("FAIL uhalf_0x12: got %h expected 00002345", rd); end
    do_access(1'b0, 3'b001, 10'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_80F1) begin failures++; $display("FAIL uhalf_0x10: got %h expected 000080f1", rd); end
    do_access(1'b0, 3'b101, 10'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80F1_2345) begin failures++; $display("FAIL mode101_word: got %h expected 80f12345", rd); end
  endtask

  task automatic test_byte_merge;
    logic [31:0] rd;
    logic er;
    int lat;
    do_access(1'b1, 3'b000, 10'h020, 32'h1122_3344, rd, er, lat);
    do_access(1'b1, 3'b011, 10'h022, 32'h0000_00AA, rd, er, lat);
    do_access(1'b0, 3'b000, 10'h020, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h1122_AA44) begin failures++; $display("FAIL byte_merge: got %h expected 1122aa44", rd); end
    do_access(1'b1, 3'b001, 10'h020, 32'h1234_BEEF, rd, er, lat);
    do_access(1'b0, 3'b000, 10'h020, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hBEEF_AA44) begin failures++; $display("FAIL half_merge: got %h expected beefaa44", rd); end
    do_access(1'b0, 3'b100, 10'h020, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_FFBE) begin failures++; $display("FAIL sbyte_0x20: got %h expected ffffffbe", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_mode  = 3'b000;
    req_addr  = 10'h040;
    req_wdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'h0);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0: got %b expected 1", req_ready); end
    @(posedge clk);
    #1;
    req_we    = 1'b0;
    req_wdata = 32'h0;
    exp_q.push_back(32'hDEAD_BEEF);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_rsp0_valid: got %b expected 1", rsp_valid); end
    exp = exp_q.pop_front();
    checks++; if (rsp_rdata !== exp) begin failures++; $display("FAIL b2b_rsp0_data: got %h expected %h", rsp_rdata, exp); end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_rsp1_valid: got %b expected 1", rsp_valid); end
    exp = exp_q.pop_front();
    checks++; if (rsp_rdata !== exp) begin failures++; $display("FAIL b2b_rsp1_data: got %h expected %h", rsp_rdata, exp); end
    @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_pulse_end: got %b expected 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b_rdata_hold: got %h expected deadbeef", rsp_rdata); end
  endtask

  task automatic test_misalign;
    logic [31:0] rd;
    logic er;
    int lat;
    do_access(1'b1, 3'b000, 10'h3FC, 32'h0000_A1B2, rd, er, lat);
    do_access(1'b1, 3'b000, 10'h000, 32'hC3D4_0000, rd, er, lat);
    do_access(1'b0, 3'b000, 10'h3FE, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_SPLIT_EN
    checks++; if (rd !== 32'hA1B2_C3D4 || er !== 1'b0) begin failures++; $display("FAIL misal_word_load: got %h err %b expected a1b2c3d4 err 0", rd, er); end
    checks++; if (lat != 2) begin failures++; $display("FAIL misal_latency: got %0d expected 2", lat); end
`else
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin failures++; $display("FAIL misal_word_err: got %h err %b expected 00000000 err 1", rd, er); end
    checks++; if (lat != 1) begin failures++; $display("FAIL misal_latency: got %0d expected 1", lat); end
`endif
    do_access(1'b1, 3'b001, 10'h023, 32'h0000_5566, rd, er, lat);
    do_access(1'b0, 3'b000, 10'h020, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_SPLIT_EN
    checks++; if (rd !== 32'hBEEF_AA55) begin failures++; $display("FAIL misal_store_w0: got %h expected beefaa55", rd); end
`else
    checks++; if (rd !== 32'hBEEF_AA44) begin failures++; $display("FAIL misal_store_w0: got %h expected beefaa44", rd); end
`endif
    do_access(1'b0, 3'b000, 10'h024, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_SPLIT_EN
    checks++; if (rd !== 32'h6600_0000) begin failures++; $display("FAIL misal_store_w1: got %h expected 66000000", rd); end
`else
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL misal_store_w1: got %h expected 00000000", rd); end
`endif
    do_access(1'b0, 3'b010, 10'h023, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_SPLIT_EN
    checks++; if (rd !== 32'h0000_5566 || er !== 1'b0) begin failures++; $display("FAIL misal_half_load: got %h err %b expected 00005566 err 0", rd, er); end
`else
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin failures++; $display("FAIL misal_half_load: got %h err %b expected 00000000 err 1", rd, er); end
`endif
    do_access(1'b0, 3'b100, 10'h3FF, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_FFB2 || er !== 1'b0) begin failures++; $display("FAIL byte_never_misal: got %h err %b expected ffffffb2 err 0", rd, er); end
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] rd;
    logic er;
    int lat;
    int cnt;
    int seen;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_mode  = 3'b000;
    req_addr  = 10'h3FE;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
    checks++; if (req_ready !== 1'b0 || dbg_state !== 2'd2) begin failures++; $display("FAIL split_beat2_state: ready %b state %0d expected ready 0 state 2", req_ready, dbg_state); end
`endif
    reset = 1'b0;
    #1;
    seen = (rsp_valid === 1'b1) ? 1 : 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL reset_drops_rsp: got %0d pulses expected 0", seen); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state_init: got %0d expected 0", dbg_state); end
    release_and_count(cnt);
    checks++; if (cnt != 256) begin failures++; $display("FAIL reinit_cycles: got %0d expected 256", cnt); end
    do_access(1'b0, 3'b000, 10'h3FC, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL cleared_3fc: got %h expected 00000000", rd); end
    do_access(1'b0, 3'b000, 10'h000, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL cleared_000: got %h expected 00000000", rd); end
    do_access(1'b0, 3'b000, 10'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0 || lat != 1) begin failures++; $display("FAIL cleared_010: got %h lat %0d expected 00000000 lat 1", rd, lat); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_store_load();
    test_byte_merge();
    test_back_to_back();
    test_misalign();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
